// File: rtl/syncfifo_prog.sv
// syncfifo_prog: single-clock FIFO with occupancy count, almost-full/almost-empty
// threshold flags and a selectable standard or first-word-fall-through read port.
// Optional sticky overflow/underflow flags are built when SYNCFIFO_ERR_FLAG_EN is defined.
module syncfifo_prog #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned FULL_TH  = DEPTH - 4,
    parameter int unsigned EMPTY_TH = 4,
    parameter int unsigned FWFT     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   full_th,
    output logic                   empty_th,
    output logic [$clog2(DEPTH):0] count
`ifdef SYNCFIFO_ERR_FLAG_EN
    ,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
    localparam logic [CW-1:0] FullThC  = CW'(FULL_TH);
    localparam logic [CW-1:0] EmptyThC = CW'(EMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          wr_acc;
    logic          rd_acc;

    // At full a concurrent read frees the slot the write lands in.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    // Status flags decode the count register directly, so they move with count.
    assign full     = (count_q == DepthC);
    assign empty    = (count_q == '0);
    assign full_th  = (count_q >= FullThC);
    assign empty_th = (count_q <= EmptyThC);
    assign count    = count_q;

    // Occupancy next state: simultaneous read and write leave it unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented whenever something is stored.
            assign data_out = empty ? '0 : mem[rd_ptr_q];
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;

            // Registered read: load the head word on an accepted pop, hold otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rd_ptr_q];
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

`ifdef SYNCFIFO_ERR_FLAG_EN
    // Sticky error flags; a read at empty counts even if a write is accepted alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & ~wr_acc) overflow <= 1'b1;
            if (rd_en & empty)   underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_syncfifo_prog.sv
// Bench for syncfifo_prog: two instances (standard and FWFT read) share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_syncfifo_prog;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;

    logic [7:0] dout0, dout1;
    logic       full0, empty0, fth0, eth0;
    logic       full1, empty1, fth1, eth1;
    logic [4:0] count0, count1;
`ifdef SYNCFIFO_ERR_FLAG_EN
    logic       ovf0, unf0, ovf1, unf1;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] exp_d0;
    bit         exp_ovf;
    bit         exp_unf;

    syncfifo_prog #(.WIDTH(8), .DEPTH(16), .FULL_TH(12), .EMPTY_TH(4), .FWFT(0)) u_std (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .rd_en    (rd_en),
        .data_out (dout0),
        .full     (full0),
        .empty    (empty0),
        .full_th  (fth0),
        .empty_th (eth0),
        .count    (count0)
`ifdef SYNCFIFO_ERR_FLAG_EN
        ,
        .overflow (ovf0),
        .underflow(unf0)
`endif
    );

    syncfifo_prog #(.WIDTH(8), .DEPTH(16), .FULL_TH(12), .EMPTY_TH(4), .FWFT(1)) u_fwft (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .rd_en    (rd_en),
        .data_out (dout1),
        .full     (full1),
        .empty    (empty1),
        .full_th  (fth1),
        .empty_th (eth1),
        .count    (count1)
`ifdef SYNCFIFO_ERR_FLAG_EN
        ,
        .overflow (ovf1),
        .underflow(unf1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model update at the active edge from the inputs the DUTs sample.
    always @(posedge clk) begin
        bit rd_ok;
        bit wr_ok;
        if (rst) begin
            q.delete();
            exp_d0  = 8'h00;
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            rd_ok = rd_en && (q.size() > 0);
            wr_ok = wr_en && ((q.size() < 16) || rd_ok);
            if (rd_en && q.size() == 0) exp_unf = 1'b1;
            if (wr_en && !wr_ok) exp_ovf = 1'b1;
            if (rd_ok) exp_d0 = q.pop_front();
            if (wr_ok) q.push_back(data_in);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int n;
        if (chk_en) begin
            n = q.size();
            chk("m_count0", int'(count0), n);
            chk("m_count1", int'(count1), n);
            chk("m_empty0", int'(empty0), int'(n == 0));
            chk("m_empty1", int'(empty1), int'(n == 0));
            chk("m_full0", int'(full0), int'(n == 16));
            chk("m_full1", int'(full1), int'(n == 16));
            chk("m_fth0", int'(fth0), int'(n >= 12));
            chk("m_fth1", int'(fth1), int'(n >= 12));
            chk("m_eth0", int'(eth0), int'(n <= 4));
            chk("m_eth1", int'(eth1), int'(n <= 4));
            chk("m_dout0", int'(dout0), int'(exp_d0));
            if (n > 0) chk("m_dout1", int'(dout1), int'(q[0]));
`ifdef SYNCFIFO_ERR_FLAG_EN
            chk("m_ovf0", int'(ovf0), int'(exp_ovf));
            chk("m_unf0", int'(unf0), int'(exp_unf));
            chk("m_ovf1", int'(ovf1), int'(exp_ovf));
            chk("m_unf1", int'(unf1), int'(exp_unf));
`endif
        end
    end

    // Drive one cycle of inputs and return at the following negedge.
    task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
        rst     = r;
        wr_en   = w;
        rd_en   = rd;
        data_in = d;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("rst_count", int'(count0), 0);
        chk("rst_empty", int'(empty0), 1);
        chk("rst_empty_th", int'(eth0), 1);
        chk("rst_full", int'(full0), 0);
        chk("rst_full_th", int'(fth0), 0);
        chk("rst_dout", int'(dout0), 0);

        // Fill 0..15, then one dropped write
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(i));
            chk("t1_count", int'(count0), i + 1);
            if (i == 3)  chk("t1_eth_at4", int'(eth0), 1);
            if (i == 4)  chk("t1_eth_at5", int'(eth0), 0);
            if (i == 10) chk("t1_fth_at11", int'(fth0), 0);
            if (i == 11) chk("t1_fth_at12", int'(fth0), 1);
            if (i == 14) chk("t1_full_at15", int'(full0), 0);
            if (i == 15) chk("t1_full_at16", int'(full0), 1);
        end
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        chk("t1_drop_count", int'(count0), 16);
        chk("t1_drop_full", int'(full0), 1);

        // Drain with registered read
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("t2_dout", int'(dout0), i);
        end
        chk("t2_empty", int'(empty0), 1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t2_hold", int'(dout0), 15);
`ifdef SYNCFIFO_ERR_FLAG_EN
        chk("t2_ovf", int'(ovf0), 1);
        chk("t2_unf", int'(unf0), 1);
`endif

        // FWFT write into empty
        step(1'b0, 1'b1, 1'b0, 8'h5A);
        chk("t3_empty", int'(empty1), 0);
        chk("t3_dout", int'(dout1), 'h5A);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t3_empty_after", int'(empty1), 1);
        chk("t3_count_after", int'(count1), 0);

        // Simultaneous read/write at full
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'(100 + i));
            chk("t4_count", int'(count0), 16);
            chk("t4_full", int'(full0), 1);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("t4_drain", int'(dout0), 104 + i);
        end

        // Simultaneous read/write at empty
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h21);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t5_pre_dout", int'(dout0), 'h21);
`ifdef SYNCFIFO_ERR_FLAG_EN
        chk("t5_pre_unf", int'(unf0), 0);
`endif
        step(1'b0, 1'b1, 1'b1, 8'h33);
        chk("t5_count", int'(count0), 1);
        chk("t5_dout", int'(dout0), 'h21);
`ifdef SYNCFIFO_ERR_FLAG_EN
        chk("t5_unf", int'(unf0), 1);
`endif

        // Reset mid-stream overrides a concurrent transfer
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        step(1'b1, 1'b1, 1'b1, 8'h77);
        chk("t6_count", int'(count0), 0);
        chk("t6_empty", int'(empty0), 1);
        chk("t6_dout", int'(dout0), 0);
`ifdef SYNCFIFO_ERR_FLAG_EN
        chk("t6_unf", int'(unf0), 0);
`endif
        step(1'b0, 1'b1, 1'b0, 8'hC1);
        chk("t6_new_count", int'(count0), 1);
        chk("t6_new_fwft", int'(dout1), 'hC1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t6_new_dout", int'(dout0), 'hC1);

        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
